// File: rtl/ysyx_23060201_wbu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060201_wbu
// Description : Write-back unit. Collects EXU (ALU) and LSU (load) results
//               over valid/ready handshakes into a small in-order FIFO and
//               drains it at one registered GPR write per cycle. It also
//               offers a combinational forwarding lookup over all
//               not-yet-written results and a 64-bit retire counter.
// Ports       : clk, rst_n                      - clock / async active-low reset
//               exu_valid/ready/rd/data         - EXU result handshake
//               lsu_valid/ready/rd/data         - LSU result handshake
//               gpr_wen/waddr/wdata             - registered GPR write port
//               fwd_raddr -> fwd_hit/fwd_data   - forwarding lookup
//               retire_cnt                      - results retired since reset
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060201_wbu #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exu_valid,
    output logic                      exu_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0]     exu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_data,
    output logic                      gpr_wen,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata,
    input  logic [GPR_ADDR_WIDTH-1:0] fwd_raddr,
    output logic                      fwd_hit,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [63:0]               retire_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
    // With both sources pushing, two free slots are needed.
    localparam logic [c_CNT_W-1:0] c_BOTH_MAX  = c_CNT_W'(DEPTH - 2);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    logic [c_PTR_W-1:0]        r_head;
    logic [c_PTR_W-1:0]        r_tail;
    logic [c_CNT_W-1:0]        r_count;
    logic [GPR_ADDR_WIDTH-1:0] r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0]     r_data [DEPTH];

    logic                      w_lsu_push;
    logic                      w_exu_push;
    logic                      w_pop;
    logic [c_PTR_W-1:0]        w_exu_slot;

    // Ready looks only at the registered occupancy; a same-cycle pop does
    // not free a slot, which keeps ready off the pop path.
    assign lsu_ready  = (r_count < c_FULL);
    assign exu_ready  = lsu_valid ? (r_count <= c_BOTH_MAX) : (r_count < c_FULL);

    assign w_lsu_push = lsu_valid & lsu_ready;
    assign w_exu_push = exu_valid & exu_ready;
    assign w_pop      = (r_count != '0);

    // LSU entry is older: it takes the tail slot, EXU goes right behind it.
    assign w_exu_slot = r_tail + c_PTR_W'(w_lsu_push);

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            gpr_wen    <= 1'b0;
            gpr_waddr  <= '0;
            gpr_wdata  <= '0;
            retire_cnt <= '0;
        end else begin
            r_tail  <= r_tail + c_PTR_W'(w_lsu_push) + c_PTR_W'(w_exu_push);
            r_count <= r_count + c_CNT_W'(w_lsu_push) + c_CNT_W'(w_exu_push)
                       - c_CNT_W'(w_pop);
            if (w_pop) begin
                r_head     <= r_head + c_PTR_ONE;
                gpr_wen    <= (r_rd[r_head] != '0);
                gpr_waddr  <= r_rd[r_head];
                gpr_wdata  <= r_data[r_head];
                retire_cnt <= retire_cnt + 64'd1;
            end else begin
                gpr_wen    <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: slots are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_lsu_push) begin
            r_rd[r_tail]   <= lsu_rd;
            r_data[r_tail] <= lsu_data;
        end
        if (w_exu_push) begin
            r_rd[w_exu_slot]   <= exu_rd;
            r_data[w_exu_slot] <= exu_data;
        end
    end

    // Forwarding: scan from the output register through oldest to youngest
    // FIFO entry, letting each later match override, so the youngest wins.
    always_comb begin
        logic [c_PTR_W-1:0] w_idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        if (fwd_raddr != '0) begin
            if (gpr_wen && (gpr_waddr == fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = gpr_wdata;
            end
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = r_head + c_PTR_W'(k);
                if ((c_CNT_W'(k) < r_count) && (r_rd[w_idx] == fwd_raddr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = r_data[w_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_wbu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060201_wbu
// Description : Self-checking bench for the write-back unit: directed vector
//               table, back-to-back stream, mid-stream reset and a random
//               phase checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060201_wbu;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        exu_valid, lsu_valid;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd, fwd_raddr, gpr_waddr;
    logic [31:0] exu_data, lsu_data, gpr_wdata, fwd_data;
    logic        gpr_wen, fwd_hit;
    logic [63:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    ysyx_23060201_wbu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .gpr_wen    (gpr_wen),
        .gpr_waddr  (gpr_waddr),
        .gpr_wdata  (gpr_wdata),
        .fwd_raddr  (fwd_raddr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Directed vectors: inputs for one cycle, expected pre-edge ready/forward
    // values, and expected registered outputs right after the edge.
    typedef struct {
        logic        ev; logic [4:0] erd; logic [31:0] ed;
        logic        lv; logic [4:0] lrd; logic [31:0] ld;
        logic [4:0]  fa;
        logic        x_er, x_lr, x_hit; logic [31:0] x_fd;
        logic        x_wen; logic [4:0] x_wa; logic [31:0] x_wd; logic [63:0] x_ret;
    } vec_t;

    vec_t vecs[18];

    // Reference model: pending results as an in-order queue.
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [63:0] m_ret;

    logic [4:0]  rec_wa[16];
    logic [31:0] rec_wd[16];
    int          nrec;
    logic [63:0] base_ret;

    initial begin
        vecs[0]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,  5'd5, 1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'h0,        64'd0};
        vecs[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd5, 1'b1,1'b1,1'b1,32'hDEADBEEF, 1'b1,5'd5,32'hDEADBEEF, 64'd1};
        vecs[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd5, 1'b1,1'b1,1'b1,32'hDEADBEEF, 1'b0,5'd5,32'hDEADBEEF, 64'd1};
        vecs[3]  = '{1'b1,5'd3,32'h11,       1'b1,5'd3,32'h22, 5'd3, 1'b1,1'b1,1'b0,32'h0,        1'b0,5'd5,32'hDEADBEEF, 64'd1};
        vecs[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd3, 1'b1,1'b1,1'b1,32'h11,       1'b1,5'd3,32'h22,       64'd2};
        vecs[5]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd3, 1'b1,1'b1,1'b1,32'h11,       1'b1,5'd3,32'h11,       64'd3};
        vecs[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd3, 1'b1,1'b1,1'b1,32'h11,       1'b0,5'd3,32'h11,       64'd3};
        vecs[7]  = '{1'b1,5'd0,32'h55,       1'b0,5'd0,32'h0,  5'd0, 1'b1,1'b1,1'b0,32'h0,        1'b0,5'd3,32'h11,       64'd3};
        vecs[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd0, 1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'h55,       64'd4};
        vecs[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd0, 1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'h55,       64'd4};
        vecs[10] = '{1'b1,5'd1,32'hA1,       1'b1,5'd2,32'hB2, 5'd1, 1'b1,1'b1,1'b0,32'h0,        1'b0,5'd0,32'h55,       64'd4};
        vecs[11] = '{1'b1,5'd4,32'hA4,       1'b1,5'd6,32'hB6, 5'd2, 1'b1,1'b1,1'b1,32'hB2,       1'b1,5'd2,32'hB2,       64'd5};
        vecs[12] = '{1'b1,5'd7,32'hA7,       1'b1,5'd8,32'hB8, 5'd6, 1'b0,1'b1,1'b1,32'hB6,       1'b1,5'd1,32'hA1,       64'd6};
        vecs[13] = '{1'b1,5'd7,32'hA7,       1'b0,5'd0,32'h0,  5'd7, 1'b1,1'b1,1'b0,32'h0,        1'b1,5'd6,32'hB6,       64'd7};
        vecs[14] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd4, 1'b1,1'b1,1'b1,32'hA4,       1'b1,5'd4,32'hA4,       64'd8};
        vecs[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd8, 1'b1,1'b1,1'b1,32'hB8,       1'b1,5'd8,32'hB8,       64'd9};
        vecs[16] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd7, 1'b1,1'b1,1'b1,32'hA7,       1'b1,5'd7,32'hA7,       64'd10};
        vecs[17] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,  5'd7, 1'b1,1'b1,1'b1,32'hA7,       1'b0,5'd7,32'hA7,       64'd10};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        fwd_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",   64'(gpr_wen),   64'd0);
        chk("rst_waddr", 64'(gpr_waddr), 64'd0);
        chk("rst_wdata", 64'(gpr_wdata), 64'd0);
        chk("rst_ret",   retire_cnt,     64'd0);
        chk("rst_exu_rdy", 64'(exu_ready), 64'd1);
        chk("rst_lsu_rdy", 64'(lsu_ready), 64'd1);
        chk("rst_fwd_hit", 64'(fwd_hit),   64'd0);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            exu_valid = vecs[i].ev; exu_rd = vecs[i].erd; exu_data = vecs[i].ed;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
            fwd_raddr = vecs[i].fa;
            #1;
            chk($sformatf("v%0d_exu_rdy", i), 64'(exu_ready), 64'(vecs[i].x_er));
            chk($sformatf("v%0d_lsu_rdy", i), 64'(lsu_ready), 64'(vecs[i].x_lr));
            chk($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit),   64'(vecs[i].x_hit));
            chk($sformatf("v%0d_fwd_dat", i), 64'(fwd_data),  64'(vecs[i].x_fd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen",   i), 64'(gpr_wen),   64'(vecs[i].x_wen));
            chk($sformatf("v%0d_waddr", i), 64'(gpr_waddr), 64'(vecs[i].x_wa));
            chk($sformatf("v%0d_wdata", i), 64'(gpr_wdata), 64'(vecs[i].x_wd));
            chk($sformatf("v%0d_ret",   i), retire_cnt,     vecs[i].x_ret);
        end
        exu_valid = 1'b0; lsu_valid = 1'b0; fwd_raddr = '0;

        // ---------------- 10 back-to-back EXU pushes ----------------
        base_ret = retire_cnt;
        nrec = 0;
        for (int i = 0; i < 10; i++) begin
            exu_valid = 1'b1; exu_rd = 5'(10 + i); exu_data = 32'h1000 + 32'(i);
            #1;
            chk($sformatf("stream%0d_rdy", i), 64'(exu_ready), 64'd1);
            @(posedge clk);
            #1;
            if (gpr_wen && nrec < 16) begin
                rec_wa[nrec] = gpr_waddr; rec_wd[nrec] = gpr_wdata; nrec++;
            end
        end
        exu_valid = 1'b0;
        for (int c = 0; c < 20 && nrec < 10; c++) begin
            @(posedge clk);
            #1;
            if (gpr_wen && nrec < 16) begin
                rec_wa[nrec] = gpr_waddr; rec_wd[nrec] = gpr_wdata; nrec++;
            end
        end
        chk("stream_nwrites", 64'(nrec), 64'd10);
        for (int j = 0; j < nrec && j < 10; j++) begin
            chk($sformatf("stream%0d_waddr", j), 64'(rec_wa[j]), 64'(10 + j));
            chk($sformatf("stream%0d_wdata", j), 64'(rec_wd[j]), 64'(32'h1000 + 32'(j)));
        end
        @(posedge clk);
        #1;
        chk("stream_ret", retire_cnt - base_ret, 64'd10);

        // ---------------- reset with 3 entries queued ----------------
        exu_valid = 1'b1; exu_rd = 5'd9;  exu_data = 32'h909;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0A;
        @(posedge clk); #1;
        exu_rd = 5'd11; exu_data = 32'hB0B;
        lsu_rd = 5'd12; lsu_data = 32'hC0C;
        @(posedge clk); #1;
        exu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_wen", 64'(gpr_wen), 64'd0);
        chk("mrst_ret", retire_cnt,   64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mrst_after%0d_wen", c), 64'(gpr_wen), 64'd0);
        end
        chk("mrst_after_ret", retire_cnt, 64'd0);

        // ---------------- random phase vs. reference model ----------------
        mq.delete();
        m_wen = 1'b0; m_wa = '0; m_wd = '0; m_ret = 64'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic x_er, x_lr, x_hit;
            logic [31:0] x_fd;
            exu_valid = ($urandom_range(0, 9) < 6);
            lsu_valid = ($urandom_range(0, 9) < 5);
            exu_rd    = 5'($urandom_range(0, 7));
            lsu_rd    = 5'($urandom_range(0, 7));
            exu_data  = $urandom;
            lsu_data  = $urandom;
            fwd_raddr = 5'($urandom_range(0, 7));
            #1;
            x_lr = (mq.size() < DEPTH);
            x_er = lsu_valid ? (mq.size() <= DEPTH - 2) : (mq.size() < DEPTH);
            x_hit = 1'b0; x_fd = '0;
            if (fwd_raddr != 0) begin
                if (m_wen && m_wa == fwd_raddr) begin x_hit = 1'b1; x_fd = m_wd; end
                foreach (mq[k]) if (mq[k].rd == fwd_raddr) begin x_hit = 1'b1; x_fd = mq[k].d; end
            end
            chk("rnd_exu_rdy", 64'(exu_ready), 64'(x_er));
            chk("rnd_lsu_rdy", 64'(lsu_ready), 64'(x_lr));
            chk("rnd_fwd_hit", 64'(fwd_hit),   64'(x_hit));
            chk("rnd_fwd_dat", 64'(fwd_data),  64'(x_fd));
            @(posedge clk);
            if (mq.size() > 0) begin
                ent_t e;
                e = mq.pop_front();
                m_wen = (e.rd != 0); m_wa = e.rd; m_wd = e.d; m_ret = m_ret + 64'd1;
            end else begin
                m_wen = 1'b0;
            end
            if (lsu_valid && x_lr) mq.push_back('{lsu_rd, lsu_data});
            if (exu_valid && x_er) mq.push_back('{exu_rd, exu_data});
            #1;
            chk("rnd_wen",   64'(gpr_wen),   64'(m_wen));
            chk("rnd_waddr", 64'(gpr_waddr), 64'(m_wa));
            chk("rnd_wdata", 64'(gpr_wdata), 64'(m_wd));
            chk("rnd_ret",   retire_cnt,     m_ret);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
